hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Pipeline-control block for the 5-stage core. It generates the ForwardAE/ForwardBE selects consumed by the E-stage operand muxes, the ForwardAD/ForwardBD selects for the D-stage branch comparator, and the StallF, StallD and FlushE controls.
- It keeps its own shadow copy of destination-register and control fields for the E, M and W stages. It also tracks a multi-cycle multiply/divide busy window with a counter.
- The forward-select encoding is shared with the operand muxes:
  - 00: register-file value
  - 01: W-stage result (ALU or DM writeback)
  - 10: M-stage ALU output

Parameters:
- REG_AW, 5, register-address width.
- MD_LATENCY, 4, cycles a multiply/divide occupies HI/LO after entering E (allowed range 1..15).

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- RsD  in  REG_AW  D-stage source register 1
- RtD  in  REG_AW  D-stage source register 2
- WriteRegD  in  REG_AW  D-stage destination register (already muxed rt/rd)
- RegWriteD  in  1  D instruction writes the register file
- MemtoRegD  in  1  D instruction is a load
- BranchD  in  1  D instruction is a branch (compare in D)
- MdStartD  in  1  D instruction is mult/div
- HiLoReadD  in  1  D instruction is mfhi/mflo
- ForwardAE  out  2  E operand A select
- ForwardBE  out  2  E operand B / store-data select
- ForwardAD  out  1  D branch operand A takes the M-stage ALU output
- ForwardBD  out  1  D branch operand B takes the M-stage ALU output
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushE  out  1  bubble ID/EX register
- MdBusy  out  1  HI/LO is being produced

Behaviour:
- Shadow registers (E, M and W stages, each with RegWrite, MemtoReg and WriteReg; E stage also holds Rs, Rt and MdStart):
  - On rst, all shadow registers clear to 0 and the counter clears to 0.
  - After reset, all outputs are 0 combinationally. Outputs are combinational from the shadow state and the D inputs; there are no output registers.
  - E stage on each edge:
    - If FlushE=1, E loads zeros (bubble).
    - Otherwise E loads {RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, MdStartD}.
  - M stage loads from E, and W stage loads from M, on every non-reset edge. There is no stall of E, M or W.
- ForwardAE:
  - 10 if RegWriteM and WriteRegM != 0 and WriteRegM == RsE.
  - Else 01 if RegWriteW and WriteRegW != 0 and WriteRegW == RsE.
  - Else 00.
  - The M-stage match has priority over the W-stage match.
- ForwardBE: identical rule with RtE in place of RsE.
- ForwardAD = (RsD != 0) and RegWriteM and WriteRegM == RsD. ForwardBD uses the same rule with RtD.
- A W-to-D path is not forwarded: the register file writes in the first half-cycle.
- lwstall = MemtoRegE and RtE != 0 and (RtE == RsD or RtE == RtD).
- branchstall = BranchD and one of the following:
  - RegWriteE and WriteRegE != 0 and WriteRegE ∈ {RsD, RtD}, or
  - MemtoRegM and WriteRegM != 0 and WriteRegM ∈ {RsD, RtD}.
- Multiply/divide counter (4-bit):
  - When MdStartE=1, the counter loads MD_LATENCY. This reloads even if the counter is nonzero.
  - Otherwise, if the counter is nonzero, it decrements by 1.
  - MdBusy = (count != 0).
- mdstall = MdBusy and (HiLoReadD or MdStartD).
- Stall outputs: StallF = StallD = FlushE = lwstall | branchstall | mdstall.
- Simultaneous stall causes OR together; a single bubble is inserted per cycle.
- A stall persists while its condition holds:
  - lwstall resolves after 1 cycle, because the load moves to M.
  - mdstall holds until the count reaches 0.
- rst asserted mid-stall: on the next edge everything clears and the stalls drop.

Decomposition:
- Shared package holds:
  - the forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - REG_AW;
  - the register-zero constant.
- One natural sub-module: md_busy_counter (load/decrement counter producing MdBusy). The rest stays flat.

Test Plan:
- E-stage add writes $8; next instruction reads $8 as Rs → ForwardAE=10 for one cycle, then ForwardAE=00 once the dependent instruction has left E.
- M=W=$9 both writing with RtE=$9 → ForwardBE=10 (M priority). With only W writing $9 → ForwardBE=01. Same scenario with WriteReg=$0 → ForwardBE=00.
- lw $10 in E, D reads $10 as Rt → StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle ForwardBE=01 (load in W, dependent instruction in E).
- beq in D using $11, with E an add writing $11 → 1-cycle stall, then ForwardAD=1. With the producer a lw → 2 stall cycles.
- mult enters E with MD_LATENCY=4, mfhi in D → MdBusy high for 4 cycles and stall for 4 cycles. Release occurs when count=0.
- Assert rst during the mdstall → all outputs 0 after the edge and the counter reads 0.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: forward-select encoding,
// register-address width and the hard-wired zero register.
package hazard_forward_unit_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_forward_unit_md_busy_counter.sv
// Multiply/divide busy window: loads MD_LATENCY when a mult/div is in E,
// then counts down to zero; busy while nonzero.
module md_busy_counter #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (start) begin
      // a new mult/div restarts the window even if one is still running
      count <= 4'(MD_LATENCY);
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: shadows E/M/W destination/control fields, derives the
// operand forwarding selects and the combined load/branch/mult-div stall.
module hazard_forward_unit #(
  parameter int unsigned REG_AW     = hazard_forward_unit_pkg::REG_AW,
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              BranchD,
  input  logic              MdStartD,
  input  logic              HiLoReadD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              MdBusy
);

  import hazard_forward_unit_pkg::*;

  localparam logic [REG_AW-1:0] RZERO = REG_AW'(REG_ZERO);

  logic [REG_AW-1:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic              RegWriteE, MemtoRegE, MdStartE;
  logic              RegWriteM, MemtoRegM;
  logic              RegWriteW, MemtoRegW;

  logic lwstall, branchstall, mdstall, stall;
  logic m_hits_a, m_hits_b, w_hits_a, w_hits_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      RsE       <= '0;
      RtE       <= '0;
      WriteRegE <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MdStartE  <= 1'b0;
      WriteRegM <= '0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      WriteRegW <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
    end else begin
      if (FlushE) begin
        RsE       <= '0;
        RtE       <= '0;
        WriteRegE <= '0;
        RegWriteE <= 1'b0;
        MemtoRegE <= 1'b0;
        MdStartE  <= 1'b0;
      end else begin
        RsE       <= RsD;
        RtE       <= RtD;
        WriteRegE <= WriteRegD;
        RegWriteE <= RegWriteD;
        MemtoRegE <= MemtoRegD;
        MdStartE  <= MdStartD;
      end
      WriteRegM <= WriteRegE;
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      WriteRegW <= WriteRegM;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
    end
  end

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_counter (
    .clk  (clk),
    .rst  (rst),
    .start(MdStartE),
    .busy (MdBusy)
  );

  always_comb begin
    m_hits_a = RegWriteM && (WriteRegM != RZERO) && (WriteRegM == RsE);
    m_hits_b = RegWriteM && (WriteRegM != RZERO) && (WriteRegM == RtE);
    w_hits_a = RegWriteW && (WriteRegW != RZERO) && (WriteRegW == RsE);
    w_hits_b = RegWriteW && (WriteRegW != RZERO) && (WriteRegW == RtE);

    ForwardAE = FWD_RF;
    if (m_hits_a)      ForwardAE = FWD_MEM;
    else if (w_hits_a) ForwardAE = FWD_WB;

    ForwardBE = FWD_RF;
    if (m_hits_b)      ForwardBE = FWD_MEM;
    else if (w_hits_b) ForwardBE = FWD_WB;

    // W needs no D-stage path: the register file writes in the first half-cycle
    ForwardAD = (RsD != RZERO) && RegWriteM && (WriteRegM == RsD);
    ForwardBD = (RtD != RZERO) && RegWriteM && (WriteRegM == RtD);

    lwstall = MemtoRegE && (RtE != RZERO) && ((RtE == RsD) || (RtE == RtD));

    branchstall = BranchD &&
      ((RegWriteE && (WriteRegE != RZERO) &&
        ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
       (MemtoRegM && (WriteRegM != RZERO) &&
        ((WriteRegM == RsD) || (WriteRegM == RtD))));

    mdstall = MdBusy && (HiLoReadD || MdStartD);

    stall  = lwstall || branchstall || mdstall;
    StallF = stall;
    StallD = stall;
    FlushE = stall;
  end

  // MemtoRegW is carried for a complete W-stage shadow; no rule consumes it
  logic unused_w;
  assign unused_w = MemtoRegW;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: forwarding, load/branch/mult-div
// stalls and reset, with hand-computed expectations.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] RsD, RtD, WriteRegD;
  logic       RegWriteD, MemtoRegD, BranchD, MdStartD, HiLoReadD;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;

  int checks   = 0;
  int failures = 0;

  hazard_forward_unit #(
    .REG_AW(5),
    .MD_LATENCY(4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .RsD      (RsD),
    .RtD      (RtD),
    .WriteRegD(WriteRegD),
    .RegWriteD(RegWriteD),
    .MemtoRegD(MemtoRegD),
    .BranchD  (BranchD),
    .MdStartD (MdStartD),
    .HiLoReadD(HiLoReadD),
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushE   (FlushE),
    .MdBusy   (MdBusy)
  );

  always #5 clk = ~clk;

  // Present one D-stage instruction and let combinational outputs settle.
  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic regwr,
                       input logic memtoreg, input logic branch,
                       input logic mdstart, input logic hiloread);
    RsD = rs; RtD = rt; WriteRegD = wr;
    RegWriteD = regwr; MemtoRegD = memtoreg; BranchD = branch;
    MdStartD = mdstart; HiLoReadD = hiloread;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_d(3, 4, 5, 1, 1, 1, 1, 1);
    tick();
    tick();
    checks++;
    if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0",
               {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy});
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_fwd_e_mem();
    set_d(1, 2, 8, 1, 0, 0, 0, 0);        // add $8
    tick();
    set_d(8, 3, 4, 1, 0, 0, 0, 0);        // uses $8 as Rs
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ForwardAE !== 2'b10) begin
      failures++;
      $display("FAIL fwdAE_mem got=%b exp=10", ForwardAE);
    end
    tick();
    checks++;
    if (ForwardAE !== 2'b00) begin
      failures++;
      $display("FAIL fwdAE_after got=%b exp=00", ForwardAE);
    end
    drain();
  endtask

  task automatic test_fwd_priority();
    set_d(1, 2, 9, 1, 0, 0, 0, 0);
    tick();
    set_d(1, 2, 9, 1, 0, 0, 0, 0);
    tick();
    set_d(0, 9, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) begin
      failures++;
      $display("FAIL fwdBE_mprio got=%b/%b exp=10/00", ForwardBE, ForwardAE);
    end
    drain();

    set_d(1, 2, 9, 1, 0, 0, 0, 0);
    tick();
    set_d(1, 2, 5, 1, 0, 0, 0, 0);
    tick();
    set_d(0, 9, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (ForwardBE !== 2'b01) begin
      failures++;
      $display("FAIL fwdBE_wb got=%b exp=01", ForwardBE);
    end
    drain();

    set_d(1, 2, 0, 1, 0, 0, 0, 0);
    tick();
    set_d(1, 2, 0, 1, 0, 0, 0, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (ForwardBE !== 2'b00) begin
      failures++;
      $display("FAIL fwdBE_zero got=%b exp=00", ForwardBE);
    end
    // $0 in M must not forward to a D branch reading $0
    set_d(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (ForwardAD !== 1'b0 || StallF !== 1'b0) begin
      failures++;
      $display("FAIL fwdAD_zero got=%b%b exp=00", ForwardAD, StallF);
    end
    drain();
  endtask

  task automatic test_lwstall();
    set_d(1, 10, 10, 1, 1, 0, 0, 0);      // lw $10
    tick();
    set_d(2, 10, 11, 1, 0, 0, 0, 0);      // reads $10 as Rt
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b111) begin
      failures++;
      $display("FAIL lwstall_on got=%b exp=111", {StallF, StallD, FlushE});
    end
    tick();
    checks++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      failures++;
      $display("FAIL lwstall_off got=%b exp=000", {StallF, StallD, FlushE});
    end
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (ForwardBE !== 2'b01) begin
      failures++;
      $display("FAIL lw_fwdBE got=%b exp=01", ForwardBE);
    end
    drain();
  endtask

  task automatic test_branch_alu();
    set_d(1, 2, 11, 1, 0, 0, 0, 0);       // add $11
    tick();
    set_d(11, 3, 0, 0, 0, 1, 0, 0);       // beq $11,$3
    checks++;
    if (StallF !== 1'b1 || ForwardAD !== 1'b0) begin
      failures++;
      $display("FAIL br_alu_stall got=%b%b exp=10", StallF, ForwardAD);
    end
    tick();
    checks++;
    if (StallF !== 1'b0 || ForwardAD !== 1'b1 || ForwardBD !== 1'b0) begin
      failures++;
      $display("FAIL br_alu_fwd got=%b%b%b exp=010", StallF, ForwardAD, ForwardBD);
    end
    drain();
  endtask

  task automatic test_branch_lw();
    int stalls = 0;
    set_d(1, 11, 11, 1, 1, 0, 0, 0);      // lw $11
    tick();
    set_d(3, 11, 0, 0, 0, 1, 0, 0);       // beq $3,$11
    for (int unsigned i = 0; i < 4; i++) begin
      if (StallF) stalls++;
      tick();
    end
    checks++;
    if (stalls != 2) begin
      failures++;
      $display("FAIL br_lw_stalls got=%0d exp=2", stalls);
    end
    drain();
  endtask

  task automatic test_md();
    int busy_cycles = 0;
    int stall_cycles = 0;
    set_d(4, 5, 0, 0, 0, 0, 1, 0);        // mult
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (MdBusy !== 1'b0) begin
      failures++;
      $display("FAIL md_before got=%b exp=0", MdBusy);
    end
    tick();
    set_d(0, 0, 12, 1, 0, 0, 0, 1);       // mfhi
    for (int unsigned i = 0; i < 8; i++) begin
      if (MdBusy) busy_cycles++;
      if (StallF) stall_cycles++;
      tick();
    end
    checks++;
    if (busy_cycles != 4 || stall_cycles != 4) begin
      failures++;
      $display("FAIL md_window got=%0d/%0d exp=4/4", busy_cycles, stall_cycles);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_d(4, 5, 0, 0, 0, 0, 1, 0);
    tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_d(0, 0, 12, 1, 0, 0, 0, 1);
    checks++;
    if (StallF !== 1'b1 || MdBusy !== 1'b1) begin
      failures++;
      $display("FAIL md_prereset got=%b%b exp=11", StallF, MdBusy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy} !== 10'b0) begin
      failures++;
      $display("FAIL rst_mid_stall got=%b exp=0",
               {ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy});
    end
    rst = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (MdBusy !== 1'b0) begin
      failures++;
      $display("FAIL md_after_rst got=%b exp=0", MdBusy);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_fwd_e_mem();
    test_fwd_priority();
    test_lwstall();
    test_branch_alu();
    test_branch_lw();
    test_md();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
